// File: rtl/instr_loader.sv
// Boot-time loader: streams machine-code words into instruction memory from address 0,
// then releases the core from reset and counts its run cycles until it reports done.
module instr_loader #(
    parameter int D  = 10,
    parameter int W  = 9,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          start_i,
    input  logic          in_valid_i,
    input  logic [W-1:0]  in_data_i,
    input  logic          in_last_i,
    output logic          in_ready_o,
    output logic          wr_en_o,
    output logic [D-1:0]  wr_addr_o,
    output logic [W-1:0]  wr_data_o,
    output logic          core_reset_o,
    input  logic          core_done_i,
    output logic [D:0]    loaded_count_o,
    output logic [CW-1:0] run_cycles_o,
    output logic          halted_o,
    output logic          error_o
);

    // state | meaning
    // IDLE  | core held in reset, waiting for start
    // LOAD  | accepting words, writing them one cycle after each handshake
    // RUN   | core released one cycle after entry, counting cycles until done
    // HALT  | core finished and held in reset; start begins a reload
    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_e;

    localparam logic [D-1:0]  PTR_MAX = '1;
    localparam logic [D-1:0]  PTR_ONE = D'(1);
    localparam logic [D:0]    CNT_ONE = (D + 1)'(1);
    localparam logic [CW-1:0] RUN_ONE = CW'(1);

    state_e        state_q;
    logic [D-1:0]  ptr_q, ptr_d;
    logic [D:0]    loaded_count_q, loaded_count_d;
    logic [CW-1:0] run_cycles_q, run_cycles_d;
    logic          wr_en_q;
    logic [D-1:0]  wr_addr_q;
    logic [W-1:0]  wr_data_q;
    logic          core_reset_q;
    logic          halted_q;
    logic          error_q;
    logic          xfer;

    assign in_ready_o = (state_q == LOAD);
    assign xfer       = in_valid_i & in_ready_o;

    assign ptr_d          = ptr_q + PTR_ONE;
    assign loaded_count_d = loaded_count_q + CNT_ONE;
    assign run_cycles_d   = (&run_cycles_q) ? run_cycles_q : run_cycles_q + RUN_ONE;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            loaded_count_q <= '0;
            run_cycles_q   <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            core_reset_q   <= 1'b1;
            halted_q       <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE, HALT: begin
                    if (start_i) begin
                        state_q        <= LOAD;
                        ptr_q          <= '0;
                        loaded_count_q <= '0;
                        run_cycles_q   <= '0;
                        halted_q       <= 1'b0;
                        error_q        <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        wr_en_q        <= 1'b1;
                        wr_addr_q      <= ptr_q;
                        wr_data_q      <= in_data_i;
                        ptr_q          <= ptr_d;
                        loaded_count_q <= loaded_count_d;
                        if (in_last_i) begin
                            state_q <= RUN;
                        end else if (ptr_q == PTR_MAX) begin
                            // memory full without a last marker: abandon the session
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                RUN: begin
                    if (core_reset_q) begin
                        // first RUN cycle still carries the final write
                        core_reset_q <= 1'b0;
                    end else begin
                        run_cycles_q <= run_cycles_d;
                        if (core_done_i) begin
                            state_q      <= HALT;
                            halted_q     <= 1'b1;
                            core_reset_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign core_reset_o   = core_reset_q;
    assign loaded_count_o = loaded_count_q;
    assign run_cycles_o   = run_cycles_q;
    assign halted_o       = halted_q;
    assign error_o        = error_q;

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time front end that sits directly upstream of the processor core.
- Accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them sequentially into the instruction memory, starting at address 0.
- Holds the core in reset until loading finishes, then releases it and counts run cycles until the core raises done.
- Supports reload after halt without a global reset.

Parameters:
D, 10, instruction memory address width (matches core program counter width)
W, 9, machine-code word width
CW, 16, run-cycle counter width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  single-cycle request to begin a load session
in_valid  input  1  in_data/in_last valid this cycle
in_data  input  W  machine-code word
in_last  input  1  marks final word of program
in_ready  output  1  loader accepts a word this cycle
wr_en  output  1  instruction memory write strobe
wr_addr  output  D  instruction memory write address
wr_data  output  W  instruction memory write data
core_reset  output  1  active-high reset to core (1 = hold)
core_done  input  1  core's done flag
loaded_count  output  D+1  words written in current session
run_cycles  output  CW  cycles core spent out of reset
halted  output  1  core finished
error  output  1  sticky overflow: memory filled without in_last

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - Outputs: core_reset=1, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, loaded_count=0, run_cycles=0, halted=0, error=0.
  - Memory contents already written are not erased.
- States: IDLE, LOAD, RUN, HALT.
- IDLE:
  - core_reset=1, in_ready=0.
  - start=1 -> LOAD; clears loaded_count, error, halted, run_cycles; write pointer set to 0.
- LOAD:
  - in_ready=1, combinationally equal to (state==LOAD).
  - Transfer = in_valid & in_ready at cycle T.
  - At T+1 (registered): wr_en=1, wr_addr=pointer, wr_data=in_data. Pointer and loaded_count increment at the T edge.
  - wr_en=0 in every cycle without a transfer in the preceding cycle. Gaps in in_valid are allowed and cost no extra cycles.
  - Transfer with in_last=1 -> RUN at T+1.
  - Transfer at pointer 2^D-1 with in_last=0: word is written, error=1, state -> IDLE at T+1. Pointer wraps to 0 but is unused.
  - Transfer at pointer 2^D-1 with in_last=1: normal finish, error stays 0.
  - start ignored.
- RUN:
  - in_ready=0.
  - core_reset is registered: remains 1 during the first RUN cycle (T+1, the final wr_en cycle) and is 0 from T+2 onward. The core never leaves reset in the same cycle as a memory write.
  - run_cycles increments every cycle core_reset=0, saturating at 2^CW-1.
  - core_done sampled 1 while core_reset=0 -> HALT next cycle. run_cycles includes the done cycle.
  - core_done while core_reset=1 is ignored. start ignored.
- HALT:
  - halted=1, core_reset=1 (registered, asserted first HALT cycle); run_cycles frozen.
  - start=1 -> LOAD with the same clears as IDLE.
- Simultaneous events:
  - in_valid together with start in IDLE: no transfer that cycle (in_ready=0).
  - start and core_done together in RUN: core_done wins.
- loaded_count is never cleared except by start or reset. It holds its value through RUN, HALT, and error.

Test Plan:
- Basic load:
  - Stimulus: start, then words 0x1A0, 0x0F3, 0x155, 0x1FF back-to-back, last on the 4th.
  - Response: wr_en pulses with wr_addr 0,1,2,3 and matching data; loaded_count=4; core_reset falls 2 cycles after the 4th handshake.
- Backpressure and gaps:
  - Stimulus: in_valid toggled 1,0,0,1,0,1 (last on 3rd word).
  - Response: exactly 3 writes at addresses 0..2; no wr_en in gap cycles; in_ready drops the cycle after the last handshake.
- Run count:
  - Stimulus: after a load, hold core_done=0 for 9 cycles of core_reset=0, then 1.
  - Response: run_cycles=10, halted=1, core_reset=1 the next cycle; start/in_valid during RUN have no effect.
- Overflow (D=3):
  - Stimulus: 8 words without in_last.
  - Response: writes to addresses 0..7, error=1, state IDLE, loaded_count=8, core_reset stays 1.
  - Follow-up: a start clears error.
- Reset mid-load:
  - Stimulus: reset=0 asynchronously after 2 of 5 words.
  - Response: wr_en=0 and core_reset=1 immediately; loaded_count=0.
  - Follow-up: after release, a fresh start reloads from address 0.
- Reload and saturation:
  - Reload: from HALT, start and load 2 words; run_cycles and halted clear, writes restart at address 0.
  - Saturation: with CW=4, 20 run cycles -> run_cycles=15.
